// File: rtl/edge_channel_collector_pkg.sv
// Shared types and defaults for the channel egress collector and the upstream pipeline.
package edge_channel_pkg;
  localparam int NUM_CHANNELS_DEF = 4;
  localparam int DATA_W_DEF       = 8;
  localparam int CHAN_W_DEF       = $clog2(NUM_CHANNELS_DEF);

  typedef logic [CHAN_W_DEF-1:0] chan_idx_t;

  // Round-robin successor of a channel index, wrapping n-1 -> 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/edge_channel_collector_if.sv
// Bundle of per-channel sources and the single tagged output lane of the collector.
interface edge_channel_collector_if
  import edge_channel_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int DATA_W       = DATA_W_DEF
) ();
  localparam int CHAN_W = $clog2(NUM_CHANNELS);

  // Handshake: a transfer happens on any side exactly in a cycle where valid and
  // ready are both high at the rising edge; a source holds valid/data until then.
  logic [NUM_CHANNELS-1:0] in_valid;
  logic [DATA_W-1:0]       in_data [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [CHAN_W-1:0]       out_chan;
  logic                    busy;
  logic [CHAN_W-1:0]       dbg_ptr;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan, busy, dbg_ptr
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan, busy, dbg_ptr
  );
endinterface

// File: rtl/edge_channel_collector_arbiter.sv
// Round-robin arbiter; ptr names the highest-priority requester and moves past each grant.
module edge_rr_arbiter
  import edge_channel_pkg::*;
#(
  parameter  int N     = NUM_CHANNELS_DEF,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] ptr
);
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr_q) + k) % N);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
        gnt[idx]  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && gnt_valid) ptr_d = IDX_W'(rr_next(int'(gnt_idx), N));
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/edge_channel_collector.sv
// Merges per-channel byte streams into one tagged stream through a single registered slot.
module edge_channel_collector
  import edge_channel_pkg::*;
#(
  parameter  int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter  int DATA_W       = DATA_W_DEF,
  localparam int CHAN_W       = $clog2(NUM_CHANNELS)
) (
  input logic                     clk,
  input logic                     rst,
  edge_channel_collector_if.slave bus
);
  logic                    slot_free;
  logic                    grant_en;
  logic [NUM_CHANNELS-1:0] req;
  logic [NUM_CHANNELS-1:0] gnt;
  logic [CHAN_W-1:0]       gnt_idx;
  logic                    gnt_valid;
  logic [CHAN_W-1:0]       ptr;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [CHAN_W-1:0] out_chan_q,  out_chan_d;

  // The slot can take a byte when it is empty or is being drained this cycle.
  assign slot_free = !out_valid_q || bus.out_ready;
  assign grant_en  = slot_free && !rst;
  assign req       = grant_en ? bus.in_valid : '0;

  edge_rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .advance   (grant_en),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .ptr       (ptr)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (gnt_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[gnt_idx];
      out_chan_d  = gnt_idx;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign bus.in_ready  = gnt;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.busy      = out_valid_q || (|bus.in_valid);
  assign bus.dbg_ptr   = ptr;
endmodule
